lcd_timing: RTL

Dot-level timing controller for the Game Boy LCD path. It sequences each line through OAM scan, pixel transfer and h-blank, and each frame through 144 visible lines and 10 v-blank lines. It drives the mode code and per-pixel write strobe that the LCD shift-register/scan-converter consumes. It also produces LY, the LY=LYC coincidence flag, and the V-blank and STAT interrupt pulses for the CPU interrupt controller.

---
 rtl/lcd_timing.sv | 84 ++++++++
 1 files changed

// File: rtl/lcd_timing.sv
// lcd_timing: Game Boy LCD dot/line sequencer producing mode, pixel strobe, LY,
// LY=LYC coincidence and the V-blank / STAT interrupt pulses.
`timescale 1ns/1ps
module lcd_timing #(
  parameter int H_TOTAL   = 456,
  parameter int OAM_LEN   = 80,
  parameter int XFER_LEN  = 172,
  parameter int FETCH_DLY = 12,
  parameter int V_VIS     = 144,
  parameter int V_TOTAL   = 154
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       lcd_on,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_en,
  output logic [1:0] mode,
  output logic       pixel_ena,
  output logic [7:0] ly,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq
);
  typedef enum logic [1:0] {HBLANK = 2'b00, VBLANK = 2'b01, OAM = 2'b10, XFER = 2'b11} mode_e;
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] X_BEG  = 9'(OAM_LEN);
  localparam logic [8:0] P_BEG  = 9'(OAM_LEN + FETCH_DLY);
  localparam logic [8:0] P_END  = 9'(OAM_LEN + XFER_LEN);
  localparam logic [7:0] L_VIS  = 8'(V_VIS);
  localparam logic [7:0] L_LAST = 8'(V_TOTAL - 1);
  logic [8:0] h_cnt_q, h_cnt_d;
  logic [7:0] ly_q, ly_d;
  mode_e      mode_q, mode_d;
  logic       pix_q, lyc_match_q, vblank_q, stat_irq_q, stat_prev_q, on_q;
  logic       h_wrap, stat_line;
  always_comb begin
    h_wrap    = ce && h_cnt_q == H_LAST;
    h_cnt_d   = !ce ? h_cnt_q : h_wrap ? '0 : h_cnt_q + 9'd1;
    ly_d      = !h_wrap ? ly_q : ly_q == L_LAST ? '0 : ly_q + 8'd1;
    mode_d    = ly_d >= L_VIS ? VBLANK : h_cnt_d < X_BEG ? OAM : h_cnt_d < P_END ? XFER : HBLANK;
    // on_q keeps the STAT line low on the first clk after enable/reset, while mode still reads 00
    stat_line = on_q & ((stat_en[0] & (mode_q == HBLANK)) | (stat_en[1] & (mode_q == VBLANK)) |
                        (stat_en[2] & (mode_q == OAM)) | (stat_en[3] & lyc_match_q));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h_cnt_q     <= '0;
      ly_q        <= '0;
      mode_q      <= HBLANK;
      pix_q       <= 1'b0;
      lyc_match_q <= 1'b0;
      vblank_q    <= 1'b0;
      stat_irq_q  <= 1'b0;
      stat_prev_q <= 1'b0;
      on_q        <= 1'b0;
    end else if (!lcd_on) begin
      h_cnt_q     <= '0;
      ly_q        <= '0;
      mode_q      <= HBLANK;
      pix_q       <= 1'b0;
      lyc_match_q <= 1'b0;
      vblank_q    <= 1'b0;
      stat_irq_q  <= 1'b0;
      stat_prev_q <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      ly_q        <= ly_d;
      mode_q      <= mode_d;
      pix_q       <= ce && ly_d < L_VIS && h_cnt_d >= P_BEG && h_cnt_d < P_END;
      lyc_match_q <= ly_d == lyc;
      vblank_q    <= mode_d == VBLANK && mode_q != VBLANK;
      stat_irq_q  <= stat_line && !stat_prev_q;
      stat_prev_q <= stat_line;
      on_q        <= 1'b1;
    end
  assign mode       = mode_q;
  assign pixel_ena  = pix_q;
  assign ly         = ly_q;
  assign lyc_match  = lyc_match_q;
  assign vblank_irq = vblank_q;
  assign stat_irq   = stat_irq_q;
endmodule
